exc_commit_ctrl: RTL

Exception commit controller between the MEM stage and `cp0_reg`. Each cycle it priority-encodes the exception flags of the MEM-stage instruction plus the pending-interrupt condition into one exception code. It waits for outstanding data-bus traffic to drain, then pulses that code to `cp0_reg`. It flushes the pipeline and hands the CP0 exception vector (or EPC for ERET) to the fetch stage over a valid/ready handshake.

---
 rtl/exc_pkg.sv | 32 +++
 rtl/exc_commit_ctrl_prio_enc.sv | 28 ++
 rtl/exc_commit_ctrl.sv | 127 ++++++++++++
 3 files changed

// File: rtl/exc_pkg.sv
// rtl/exc_pkg.sv - exception codes, flag bit positions and FSM states for the commit controller
package exc_pkg;

  localparam logic [31:0] EXC_INT     = 32'h01;
  localparam logic [31:0] EXC_ADEL    = 32'h04;
  localparam logic [31:0] EXC_ADES    = 32'h05;
  localparam logic [31:0] EXC_SYS     = 32'h08;
  localparam logic [31:0] EXC_BP      = 32'h09;
  localparam logic [31:0] EXC_RI      = 32'h0a;
  localparam logic [31:0] EXC_OV      = 32'h0c;
  localparam logic [31:0] EXC_TR      = 32'h0d;
  localparam logic [31:0] EXC_ERET    = 32'h0e;
  localparam logic [31:0] EXC_ADEL_IF = 32'h0f;

  localparam int FLAG_W       = 9;
  localparam int FLAG_ADEL_IF = 0;
  localparam int FLAG_RI      = 1;
  localparam int FLAG_OV      = 2;
  localparam int FLAG_TRAP    = 3;
  localparam int FLAG_SYS     = 4;
  localparam int FLAG_BP      = 5;
  localparam int FLAG_ADEL    = 6;
  localparam int FLAG_ADES    = 7;
  localparam int FLAG_RSVD    = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_MEM,
    ST_REDIRECT
  } state_e;

endpackage

// File: rtl/exc_commit_ctrl_prio_enc.sv
// rtl/exc_commit_ctrl_prio_enc.sv - combinational priority encoder for exception code selection
module exc_prio_enc
  import exc_pkg::*;
(
  input  logic              int_i,
  input  logic [FLAG_W-1:0] exc_flags_i,
  input  logic              eret_i,
  output logic [31:0]       code_o
);

  logic unused_rsvd;
  assign unused_rsvd = exc_flags_i[FLAG_RSVD];

  always_comb begin
    code_o = '0;
    if (int_i)                           code_o = EXC_INT;
    else if (exc_flags_i[FLAG_ADEL_IF])  code_o = EXC_ADEL_IF;
    else if (exc_flags_i[FLAG_RI])       code_o = EXC_RI;
    else if (exc_flags_i[FLAG_OV])       code_o = EXC_OV;
    else if (exc_flags_i[FLAG_TRAP])     code_o = EXC_TR;
    else if (exc_flags_i[FLAG_SYS])      code_o = EXC_SYS;
    else if (exc_flags_i[FLAG_BP])       code_o = EXC_BP;
    else if (exc_flags_i[FLAG_ADEL])     code_o = EXC_ADEL;
    else if (exc_flags_i[FLAG_ADES])     code_o = EXC_ADES;
    else if (eret_i)                     code_o = EXC_ERET;
  end

endmodule

// File: rtl/exc_commit_ctrl.sv
// rtl/exc_commit_ctrl.sv - commits MEM-stage exceptions to cp0_reg and redirects fetch
module exc_commit_ctrl
  import exc_pkg::*;
#(
  parameter int unsigned COOLDOWN = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inst_valid_i,
  input  logic [FLAG_W-1:0] exc_flags_i,
  input  logic              eret_i,
  input  logic [31:0]       status_i,
  input  logic [31:0]       cause_i,
  input  logic [31:0]       exception_vector_i,
  input  logic              cp0_sc_we_i,
  input  logic              mem_busy_i,
  output logic [31:0]       except_type_o,
  output logic              flush_o,
  output logic              stall_o,
  output logic              redirect_valid_o,
  output logic [31:0]       redirect_pc_o,
  input  logic              redirect_ready_i
);

  localparam int CW = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;

  state_e        state_q, state_d;
  logic          int_q, int_d;
  logic [CW-1:0] cool_q, cool_d;
  logic [31:0]   code_q, code_d;
  logic [31:0]   pc_q, pc_d;
  logic          rv_q, rv_d;

  logic [31:0]   enc_code;
  logic [31:0]   commit_code;
  logic          flush;
  logic          stall;
  logic          req;

  logic unused_bits;
  assign unused_bits = ^{status_i[31:16], status_i[7:2], cause_i[31:16], cause_i[7:0]};

  exc_prio_enc u_prio_enc (
    .int_i       (int_q),
    .exc_flags_i (exc_flags_i),
    .eret_i      (eret_i),
    .code_o      (enc_code)
  );

  assign req = inst_valid_i && (enc_code != '0);

  always_comb begin
    state_d     = state_q;
    code_d      = code_q;
    pc_d        = pc_q;
    rv_d        = rv_q;
    commit_code = '0;
    flush       = 1'b0;
    stall       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req) begin
          if (mem_busy_i) begin
            stall   = 1'b1;
            code_d  = enc_code;
            state_d = ST_WAIT_MEM;
          end else begin
            commit_code = enc_code;
          end
        end
      end
      // The code captured on entry is held; late interrupts cannot replace it.
      ST_WAIT_MEM: begin
        if (mem_busy_i) stall = 1'b1;
        else            commit_code = code_q;
      end
      ST_REDIRECT: begin
        flush = 1'b1;
        if (redirect_ready_i) begin
          state_d = ST_IDLE;
          rv_d    = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (commit_code != '0) begin
      flush   = 1'b1;
      pc_d    = exception_vector_i;
      rv_d    = 1'b1;
      state_d = ST_REDIRECT;
    end

    // Reload beats decrement so back-to-back Status/Cause writes keep interrupts masked.
    if ((commit_code == EXC_ERET) || cp0_sc_we_i) cool_d = CW'(COOLDOWN);
    else if (cool_q != '0)                        cool_d = cool_q - CW'(1);
    else                                          cool_d = '0;

    int_d = status_i[0] & ~status_i[1] & (|(status_i[15:8] & cause_i[15:8])) & (cool_q == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      int_q   <= 1'b0;
      cool_q  <= '0;
      code_q  <= '0;
      pc_q    <= '0;
      rv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      int_q   <= int_d;
      cool_q  <= cool_d;
      code_q  <= code_d;
      pc_q    <= pc_d;
      rv_q    <= rv_d;
    end
  end

  assign except_type_o    = rst ? 32'h0 : commit_code;
  assign flush_o          = rst ? 1'b0 : flush;
  assign stall_o          = rst ? 1'b0 : stall;
  assign redirect_valid_o = rv_q;
  assign redirect_pc_o    = pc_q;

endmodule
